// File: rtl/fp_mul_sched_if.sv
// Bundle of requester, shared-multiplier and result-consumer signals for fp_mul_sched.
// slave is the scheduler's view; master is the surrounding requesters/multiplier/consumer.
interface fp_mul_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*DATA_W-1:0] req_a_i;
  logic [NUM_REQ*DATA_W-1:0] req_b_i;
  logic [DATA_W-1:0]         mul_a_o;
  logic [DATA_W-1:0]         mul_b_o;
  logic [DATA_W-1:0]         mul_res_i;
  logic                      res_valid_o;
  logic                      res_ready_i;
  logic [ID_W-1:0]           res_id_o;
  logic [DATA_W-1:0]         res_data_o;
  logic                      busy_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, mul_res_i, res_ready_i,
    output req_ready_o, mul_a_o, mul_b_o, res_valid_o, res_id_o, res_data_o, busy_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, mul_res_i, res_ready_i,
    input  req_ready_o, mul_a_o, mul_b_o, res_valid_o, res_id_o, res_data_o, busy_o
  );
endinterface

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler feeding one shared external fp_mul via an operand stage (S1)
// and a result stage (S2). Define FP_MUL_SCHED_FIXED_PRIO_EN for lowest-index-wins priority.
module fp_mul_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic          clk,
  input  logic          rst,
  fp_mul_sched_if.slave bus
);
  logic              r_s1_vld;
  logic [ID_W-1:0]   r_s1_id;
  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;
  logic              r_res_valid;
  logic [ID_W-1:0]   r_res_id;
  logic [DATA_W-1:0] r_res_data;

  logic               w_s2_adv;
  logic               w_s1_free;
  logic               w_grant_vld;
  logic               w_grant_en;
  logic [ID_W-1:0]    w_grant_id;
  logic [NUM_REQ-1:0] w_grant_vec;
  logic [ID_W-1:0]    w_rr_ptr;

  assign w_s2_adv  = r_s1_vld && (!r_res_valid || bus.res_ready_i);
  assign w_s1_free = !r_s1_vld || w_s2_adv;

  // Search for the first valid requester starting at the pointer, wrapping at NUM_REQ-1.
  always_comb begin
    logic [ID_W:0] v_sum;
    logic [ID_W:0] v_idx;
    logic          v_hit;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    v_sum       = '0;
    v_idx       = '0;
    v_hit       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      v_sum       = {1'b0, w_rr_ptr} + (ID_W+1)'(i);
      v_idx       = (v_sum >= (ID_W+1)'(NUM_REQ)) ? (v_sum - (ID_W+1)'(NUM_REQ)) : v_sum;
      v_hit       = !w_grant_vld && bus.req_valid_i[v_idx[ID_W-1:0]];
      w_grant_id  = v_hit ? v_idx[ID_W-1:0] : w_grant_id;
      w_grant_vld = w_grant_vld | v_hit;
    end
  end

  assign w_grant_en      = w_grant_vld && w_s1_free && !rst;
  assign w_grant_vec     = w_grant_en ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign bus.req_ready_o = w_grant_vec;

`ifdef FP_MUL_SCHED_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] w_ptr_nxt;

  assign w_ptr_nxt = (w_grant_id == ID_W'(NUM_REQ-1)) ? '0 : (w_grant_id + ID_W'(1));
  assign w_rr_ptr  = r_rr_ptr;

  // Pointer moves past the winner only on an actual transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant_en) begin
      r_rr_ptr <= w_ptr_nxt;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`endif

  // Two-stage pipeline: pop of S2, S1->S2 advance and a new grant into S1 may share a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s1_id     <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
    end else begin
      if (w_s2_adv) begin
        r_res_valid <= 1'b1;
        r_res_id    <= r_s1_id;
        r_res_data  <= bus.mul_res_i;
      end else if (r_res_valid && bus.res_ready_i) begin
        r_res_valid <= 1'b0;
      end else begin
        r_res_valid <= r_res_valid;
      end

      if (w_grant_en) begin
        r_s1_vld <= 1'b1;
        r_s1_id  <= w_grant_id;
        r_mul_a  <= bus.req_a_i[int'(w_grant_id)*DATA_W +: DATA_W];
        r_mul_b  <= bus.req_b_i[int'(w_grant_id)*DATA_W +: DATA_W];
      end else if (w_s2_adv) begin
        r_s1_vld <= 1'b0;
      end else begin
        r_s1_vld <= r_s1_vld;
      end
    end
  end

  assign bus.mul_a_o     = r_mul_a;
  assign bus.mul_b_o     = r_mul_b;
  assign bus.res_valid_o = r_res_valid;
  assign bus.res_id_o    = r_res_id;
  assign bus.res_data_o  = r_res_data;
  assign bus.busy_o      = r_s1_vld || r_res_valid;
endmodule

// File: tb/tb_fp_mul_sched.sv
// Scoreboard bench for fp_mul_sched; a behavioural single-precision multiplier stands in
// for the external fp_mul and also produces the expected products.
`timescale 1ns/1ps
module tb_fp_mul_sched;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_pop = 0;

  fp_mul_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  fp_mul_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Truncating multiply for normal operands and zero; enough for exactly representable products.
  function automatic logic [31:0] fp_mul_model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {s, e[7:0], m};
  endfunction

  assign bus.mul_res_i = fp_mul_model(bus.mul_a_o, bus.mul_b_o);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
    bus.req_a_i[k*DATA_W +: DATA_W] = a;
    bus.req_b_i[k*DATA_W +: DATA_W] = b;
  endtask

  // Run until every requester has been served and the pipeline is empty, within a budget.
  task automatic drain(input string tag, input int max_cycles);
    logic [NUM_REQ-1:0] g;
    int c;
    c = 0;
    while ((bus.req_valid_i != '0 || bus.busy_o) && c < max_cycles) begin
      #1;
      g = bus.req_ready_o;
      tick();
      bus.req_valid_i = bus.req_valid_i & ~g;
      c++;
    end
    chk({tag, "_idle"}, 64'(bus.busy_o), 64'd0);
    chk({tag, "_served"}, 64'(bus.req_valid_i), 64'd0);
  endtask

  // Scoreboard: push on each accepted request, pop and compare on each consumed result.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      chk("ready_onehot", 64'($onehot0(bus.req_ready_o)), 64'd1);
      if (bus.res_valid_o && bus.res_ready_i) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk("res_id", 64'(bus.res_id_o), 64'(e.id));
          chk("res_data", 64'(bus.res_data_o), 64'(e.data));
          n_pop++;
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (bus.req_valid_i[k] && bus.req_ready_o[k]) begin
          e.id   = ID_W'(k);
          e.data = fp_mul_model(bus.req_a_i[k*DATA_W +: DATA_W], bus.req_b_i[k*DATA_W +: DATA_W]);
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] exp_g;
    int pops0;

    rst = 1'b1;
    bus.req_valid_i = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.res_ready_i = 1'b0;
    tick();
    bus.req_valid_i = 4'b1111;
    #1;
    chk("rst_ready_forced0", 64'(bus.req_ready_o), 64'd0);
    bus.req_valid_i = '0;
    tick();
    rst = 1'b0;
    chk("rst_mul_a", 64'(bus.mul_a_o), 64'd0);
    chk("rst_mul_b", 64'(bus.mul_b_o), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid_o), 64'd0);
    chk("rst_res_id", 64'(bus.res_id_o), 64'd0);
    chk("rst_res_data", 64'(bus.res_data_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);

    // Single op from requester 1: 1.5 * 2.0
    set_op(1, 32'h3FC00000, 32'h40000000);
    bus.req_valid_i = 4'b0010;
    bus.res_ready_i = 1'b1;
    #1;
    chk("single_ready", 64'(bus.req_ready_o), 64'h2);
    tick();
    bus.req_valid_i = '0;
    chk("single_s1_valid_lat", 64'(bus.res_valid_o), 64'd0);
    chk("single_mul_a", 64'(bus.mul_a_o), 64'h3FC00000);
    chk("single_busy", 64'(bus.busy_o), 64'd1);
    tick();
    chk("single_res_valid", 64'(bus.res_valid_o), 64'd1);
    chk("single_res_data", 64'(bus.res_data_o), 64'h40400000);
    chk("single_res_id", 64'(bus.res_id_o), 64'd1);
    tick();
    chk("single_busy_after_pop", 64'(bus.busy_o), 64'd0);

    // Round-robin from a freshly reset pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      set_op(k, 32'h3F800000 + (32'(k) << 21), 32'h40000000 + (32'(k) << 20));
    bus.req_valid_i = 4'b1111;
    bus.res_ready_i = 1'b1;
    pops0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      #1;
`ifdef FP_MUL_SCHED_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'(1 << (i % NUM_REQ));
`endif
      chk("rr_grant", 64'(bus.req_ready_o), 64'(exp_g));
      if (i >= 2) chk("rr_one_per_cycle", 64'(bus.res_valid_o), 64'd1);
      tick();
    end
    bus.req_valid_i = '0;
    drain("rr", 10);
    chk("rr_pop_count", 64'(n_pop - pops0), 64'd8);

    // Backpressure: fill both stages, stall for 3 cycles, then release
    for (int k = 0; k < NUM_REQ; k++)
      set_op(k, 32'h40000000 + (32'(k) << 22), 32'h3F000000 + (32'(k) << 21));
    bus.res_ready_i = 1'b0;
    bus.req_valid_i = 4'b1111;
    pops0 = n_pop;
    for (int c = 0; c < 2; c++) begin
      #1;
      g = bus.req_ready_o;
      chk("bp_fill_grant", 64'(g), 64'(4'(1 << c)));
      tick();
      bus.req_valid_i = bus.req_valid_i & ~g;
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready_zero", 64'(bus.req_ready_o), 64'd0);
      chk("bp_res_valid", 64'(bus.res_valid_o), 64'd1);
      chk("bp_res_id_hold", 64'(bus.res_id_o), 64'd0);
      chk("bp_res_data_hold", 64'(bus.res_data_o), 64'(fp_mul_model(32'h40000000, 32'h3F000000)));
      tick();
    end
    bus.res_ready_i = 1'b1;
    #1;
    chk("bp_release_grant", 64'(bus.req_ready_o), 64'h4);
    drain("bp", 20);
    chk("bp_pop_count", 64'(n_pop - pops0), 64'd4);

    // Sign: -1.0 * 4.0 from requester 3
    set_op(3, 32'hBF800000, 32'h40800000);
    bus.req_valid_i = 4'b1000;
    #1;
    chk("sign_ready", 64'(bus.req_ready_o), 64'h8);
    tick();
    bus.req_valid_i = '0;
    tick();
    chk("sign_res_valid", 64'(bus.res_valid_o), 64'd1);
    chk("sign_res_data", 64'(bus.res_data_o), 64'hC0800000);
    chk("sign_res_id", 64'(bus.res_id_o), 64'd3);
    tick();
    chk("sign_busy_after_pop", 64'(bus.busy_o), 64'd0);

    // Reset while FULL
    for (int k = 0; k < NUM_REQ; k++)
      set_op(k, 32'h3F800000 + (32'(k) << 22), 32'h3F800000);
    bus.res_ready_i = 1'b0;
    bus.req_valid_i = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      #1;
      g = bus.req_ready_o;
      tick();
      bus.req_valid_i = bus.req_valid_i & ~g;
    end
    chk("midrst_full_busy", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_ready_forced0", 64'(bus.req_ready_o), 64'd0);
    tick();
    rst = 1'b0;
    chk("midrst_res_valid", 64'(bus.res_valid_o), 64'd0);
    chk("midrst_res_id", 64'(bus.res_id_o), 64'd0);
    chk("midrst_res_data", 64'(bus.res_data_o), 64'd0);
    chk("midrst_mul_a", 64'(bus.mul_a_o), 64'd0);
    chk("midrst_mul_b", 64'(bus.mul_b_o), 64'd0);
    chk("midrst_busy", 64'(bus.busy_o), 64'd0);
    bus.req_valid_i = 4'b1111;
    #1;
    chk("midrst_first_grant", 64'(bus.req_ready_o), 64'h1);
    bus.res_ready_i = 1'b1;
    drain("midrst", 20);

`ifdef FP_MUL_SCHED_FIXED_PRIO_EN
    // Requester 2 starves while requester 0 stays valid
    set_op(0, 32'h40000000, 32'h40000000);
    set_op(2, 32'h40400000, 32'h40000000);
    bus.req_valid_i = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("fixed_prio_grant0", 64'(bus.req_ready_o), 64'h1);
      tick();
    end
    bus.req_valid_i[0] = 1'b0;
    #1;
    chk("fixed_prio_grant2", 64'(bus.req_ready_o), 64'h4);
    drain("fixed", 10);
`endif

    tick();
    tick();
    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fp_mul_sched.md
# fp_mul_sched

Round-robin scheduler sharing one combinational `fp_mul` (IEEE-754 single, DATA_W=32) among NUM_REQ requesters. Accepts at most one operand pair per cycle via valid/ready, registers operands into the multiplier, captures the product in an output register, and returns it tagged with the requester ID under consumer backpressure. Sits between the requesting engines and the single shared `fp_mul` instance, which is external to this block.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width; the multiplier datapath is INT_W=9, FRAC_W=23
- ID_W, 2, requester ID width, equal to clog2(NUM_REQ)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester operand valid
- req_ready_o  out  NUM_REQ  per-requester grant; one-hot or zero
- req_a_i  in  NUM_REQ*DATA_W  operand A; requester k occupies bits [k*DATA_W +: DATA_W]
- req_b_i  in  NUM_REQ*DATA_W  operand B; same packing as req_a_i
- mul_a_o  out  DATA_W  registered operand A to `fp_mul` i_data_a
- mul_b_o  out  DATA_W  registered operand B to `fp_mul` i_data_b
- mul_res_i  in  DATA_W  `fp_mul` fp_mul_o, combinational from mul_a_o/mul_b_o
- res_valid_o  out  1  result valid
- res_ready_i  in  1  consumer accepts result
- res_id_o  out  ID_W  requester index of the result
- res_data_o  out  DATA_W  product
- busy_o  out  1  any pipeline stage occupied

## Operation
- Two stages:
  - S1 is the operand register: s1_vld, s1_id, mul_a_o, mul_b_o.
  - S2 is the result register: res_valid_o, res_id_o, res_data_o.
- Occupancy states (s1_vld, res_valid_o):
  - EMPTY: both 0.
  - S1_ONLY: S1 occupied, S2 empty.
  - S2_ONLY: S2 occupied, S1 empty.
  - FULL: both occupied.
- Stall rules:
  - s2_adv = s1_vld && (!res_valid_o || res_ready_i).
  - s1_free = !s1_vld || s2_adv.
- Arbitration:
  - When s1_free, grant the first requester with req_valid_i=1, searching from rr_ptr upward with wrap at NUM_REQ-1 → 0.
  - req_ready_o[g]=1 for the granted requester only. It is combinational from req_valid_i and the state.
- Transfer on req_valid_i[g] && req_ready_o[g]:
  - S1 loads the operands of g, s1_id=g, s1_vld=1.
  - rr_ptr updates to (g+1) mod NUM_REQ.
  - rr_ptr is unchanged when there is no grant.
- On s2_adv: res_data_o ← mul_res_i, res_id_o ← s1_id, res_valid_o ← 1.
- Consumer handshake:
  - res_valid_o && res_ready_i without s2_adv → res_valid_o ← 0.
  - res_data_o and res_id_o hold their last value.
- Simultaneous pop of S2, advance S1→S2, and new grant into S1 all occur in the same cycle. Full throughput is 1 op/cycle.
- Requesters hold req_valid_i and operands stable until granted. The block never drops an accepted op.
- No arithmetic is performed here. Rounding, NaN and Inf handling is entirely `fp_mul`'s.
- busy_o = s1_vld || res_valid_o.

## Timing
- Reset (rst=1 at a clock edge) clears:
  - all registered outputs: mul_a_o, mul_b_o, res_valid_o, res_id_o, res_data_o to 0; busy_o then reads 0.
  - s1_vld and rr_ptr to 0.
- req_ready_o is forced to 0 while rst=1.
- Reset mid-operation discards in-flight ops. No result is emitted for them.
- Latency: an op accepted at edge N has res_valid_o=1 after edge N+1 with no stall. This is 2 registers: S1 at edge N, S2 at edge N+1.
- Backpressure:
  - With res_ready_i=0 and FULL, req_ready_o is all 0 and S1/S2 hold.
  - FULL resolves 1 cycle after res_ready_i rises.
- The combinational path mul_a_o/mul_b_o → `fp_mul` → res_data_o D-input must fit in one CYCLE (10 ns).

## Configuration
- FP_MUL_SCHED_FIXED_PRIO_EN:
  - Defined: fixed priority. The lowest index wins and rr_ptr is removed (always 0).
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Single op: requester 1 sends 0x3FC00000 × 0x40000000 → res_valid_o after 2 edges with res_data_o=0x40400000, res_id_o=1; busy_o returns to 0 after the pop.
- Round-robin: all 4 req_valid_i held high, res_ready_i=1, operands per requester distinct → grant order 0,1,2,3,0,…; one result per cycle; IDs in the same order.
- Backpressure: 4 ops queued, res_ready_i=0 for 3 cycles once FULL → req_ready_o=0, res_data_o/res_id_o stable; after release every op is delivered exactly once, in order, with no loss.
- Sign check: -1.0 (0xBF800000) × 4.0 (0x40800000) from requester 3 → 0xC0800000, id 3.
- Reset mid-op: rst=1 for 1 cycle while FULL → next cycle every output is 0 and rr_ptr=0; the first grant after reset goes to requester 0.
- With FP_MUL_SCHED_FIXED_PRIO_EN defined, requesters 0 and 2 held valid → requester 0 is always granted and requester 2 starves until req_valid_i[0] drops.
